// File: rtl/wb_select_unit.sv
// Registered writeback-select stage: RV64I/RV32I load alignment, SLT results, per-opcode write gating, timed load wait.
// Latency: 1 cycle after accept for non-loads, 1 cycle after mem_rvalid (or timeout) for loads; in_ready low outside IDLE.
// Optional build macro WB_MISALIGN_TRAP_EN: misaligned loads complete immediately with out_err instead of waiting.
module wb_select_unit #(
    parameter int XLEN         = 64,
    parameter int NSRC         = 4,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               inst,
    input  logic [$clog2(NSRC)-1:0]   sel,
    input  logic [NSRC*XLEN-1:0]      src_data,
    input  logic                      less_flag,
    input  logic [$clog2(XLEN/8)-1:0] addr_lo,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      out_valid,
    output logic                      out_we,
    output logic [4:0]                out_rd,
    output logic [XLEN-1:0]           out_data,
    output logic                      out_err
);
    localparam int AW = $clog2(XLEN/8);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [AW-1:0]   addr_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            accept;
    logic [XLEN-1:0] src_sel;
    logic            known, is_slt, nl_we;
    logic [XLEN-1:0] nl_data;
    logic [XLEN-1:0] lane, ld_data;
    logic            ld_err;
    logic            misaligned;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rd     = inst[11:7];
    assign accept = in_valid && in_ready;

    // Out-of-range sel leaves src_sel at zero.
    always_comb begin
        src_sel = '0;
        for (int k = 0; k < NSRC; k++)
            if (int'(sel) == k) src_sel = src_data[k*XLEN +: XLEN];
    end

    always_comb begin
        known  = (opcode == OP_OP) || (opcode == OP_IMM) || (opcode == OP_AUIPC) ||
                 (opcode == OP_LUI) || (opcode == OP_JAL) || (opcode == OP_JALR) ||
                 (opcode == OP_SYSTEM) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        is_slt = (funct3[2:1] == 2'b01) &&
                 ((opcode == OP_IMM) || ((opcode == OP_OP) && (inst[31:25] == 7'b0)));
        nl_data = '0;
        if (known) nl_data = is_slt ? XLEN'(less_flag) : src_sel;
        nl_we = known && (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != 5'd0);
    end

    // Bytes shifted past the top of the word read as zero.
    always_comb begin
        lane    = mem_rdata >> {addr_q, 3'b000};
        ld_data = '0;
        ld_err  = 1'b0;
        case (f3_q)
            3'b000:  ld_data = XLEN'($signed(lane[7:0]));
            3'b001:  ld_data = XLEN'($signed(lane[15:0]));
            3'b010:  ld_data = XLEN'($signed(lane[31:0]));
            3'b011:  if (XLEN == 64) ld_data = lane; else ld_err = 1'b1;
            3'b100:  ld_data = XLEN'(lane[7:0]);
            3'b101:  ld_data = XLEN'(lane[15:0]);
            3'b110:  if (XLEN == 64) ld_data = XLEN'(lane[31:0]); else ld_err = 1'b1;
            default: ld_err = 1'b1;
        endcase
    end

    always_comb begin
        logic [2:0] a3, mask;
        a3 = 3'(addr_lo);
        case (funct3[1:0])
            2'b00:   mask = 3'b000;
            2'b01:   mask = 3'b001;
            2'b10:   mask = 3'b011;
            default: mask = 3'b111;
        endcase
        misaligned = |(a3 & mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (opcode == OP_LOAD) begin
`ifdef WB_MISALIGN_TRAP_EN
                            if (misaligned) begin
                                state     <= RESP;
                                out_valid <= 1'b1;
                                out_we    <= 1'b0;
                                out_rd    <= rd;
                                out_data  <= '0;
                                out_err   <= 1'b1;
                            end else begin
                                state <= WAIT_LOAD;
                            end
`else
                            state <= WAIT_LOAD;
`endif
                            f3_q   <= funct3;
                            rd_q   <= rd;
                            addr_q <= addr_lo;
                            cnt    <= '0;
                        end else begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_we    <= nl_we;
                            out_rd    <= rd;
                            out_data  <= nl_data;
                            out_err   <= 1'b0;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // Response data takes priority over a coincident timeout.
                    if (mem_rvalid) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_rd    <= rd_q;
                        out_data  <= ld_err ? '0 : ld_data;
                        out_we    <= !ld_err && (rd_q != 5'd0);
                        out_err   <= ld_err;
                    end else if (cnt == CW'(LOAD_TIMEOUT)) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_rd    <= rd_q;
                        out_data  <= '0;
                        out_we    <= 1'b0;
                        out_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit (XLEN=64, NSRC=4, LOAD_TIMEOUT=3): vector table for non-loads, sequences for loads/timeout/reset.
module tb_wb_select_unit;
    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  inst;
    logic [1:0]   sel;
    logic [255:0] src_data;
    logic         less_flag;
    logic [2:0]   addr_lo;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;
    logic         out_valid;
    logic         out_we;
    logic [4:0]   out_rd;
    logic [63:0]  out_data;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] SRC0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] SRC1 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] SRC2 = 64'h0000_0000_0000_ABCD;
    localparam logic [63:0] SRC3 = 64'hDEAD_BEEF_0000_0001;

    wb_select_unit #(.XLEN(64), .NSRC(4), .LOAD_TIMEOUT(3)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .sel(sel), .src_data(src_data), .less_flag(less_flag),
        .addr_lo(addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .out_err(out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  sel;
        logic        less;
        logic [63:0] exp_data;
        logic        exp_we;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'b0, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_nl(input vec_t v, input int idx);
        inst = v.inst; sel = v.sel; less_flag = v.less; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_ready", idx), 64'(in_ready), 64'd0);
        chk($sformatf("v%0d_data", idx), out_data, v.exp_data);
        chk($sformatf("v%0d_we", idx), 64'(out_we), 64'(v.exp_we));
        chk($sformatf("v%0d_rd", idx), 64'(out_rd), 64'(v.exp_rd));
        chk($sformatf("v%0d_err", idx), 64'(out_err), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", idx), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_ready_back", idx), 64'(in_ready), 64'd1);
        chk($sformatf("v%0d_hold", idx), out_data, v.exp_data);
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [2:0] a, input logic [63:0] rdata, input int delay,
                           input logic [63:0] exp_data, input logic exp_we, input logic exp_err);
        inst = mk(7'd0, f3, rd, 7'b0000011); addr_lo = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_ready_wait"}, 64'(in_ready), 64'd0);
        repeat (delay - 1) begin
            @(posedge clk); #1;
        end
        chk({name, "_no_early"}, 64'(out_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_we"}, 64'(out_we), 64'(exp_we));
        chk({name, "_err"}, 64'(out_err), 64'(exp_err));
        chk({name, "_rd"}, 64'(out_rd), 64'(rd));
        @(posedge clk); #1;
        chk({name, "_pulse"}, 64'(out_valid), 64'd0);
        chk({name, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic got;

        vecs[0] = '{mk(7'd0, 3'b010, 5'd7, 7'b0010011), 2'd0, 1'b1, 64'd1, 1'b1, 5'd7};
        vecs[1] = '{mk(7'd0, 3'b011, 5'd7, 7'b0110011), 2'd0, 1'b0, 64'd0, 1'b1, 5'd7};
        vecs[2] = '{mk(7'd0, 3'b011, 5'd3, 7'b0100011), 2'd2, 1'b1, SRC2, 1'b0, 5'd3};
        vecs[3] = '{mk(7'd0, 3'b000, 5'd0, 7'b0010011), 2'd1, 1'b0, SRC1, 1'b0, 5'd0};
        vecs[4] = '{mk(7'd0, 3'b000, 5'd9, 7'b0110011), 2'd3, 1'b1, SRC3, 1'b1, 5'd9};
        vecs[5] = '{mk(7'h20, 3'b010, 5'd10, 7'b0110011), 2'd0, 1'b1, SRC0, 1'b1, 5'd10};
        vecs[6] = '{mk(7'd0, 3'b001, 5'd2, 7'b1100011), 2'd1, 1'b0, SRC1, 1'b0, 5'd2};
        vecs[7] = '{mk(7'd0, 3'b000, 5'd4, 7'b1111111), 2'd1, 1'b0, 64'd0, 1'b0, 5'd4};
        vecs[8] = '{mk(7'd0, 3'b000, 5'd1, 7'b0110111), 2'd2, 1'b0, SRC2, 1'b1, 5'd1};
        vecs[9] = '{mk(7'd0, 3'b011, 5'd0, 7'b0010011), 2'd0, 1'b1, 64'd1, 1'b0, 5'd0};

        reset_n = 1'b0; in_valid = 1'b0; inst = '0; sel = '0; less_flag = 1'b0;
        addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        src_data = {SRC3, SRC2, SRC1, SRC0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_we", 64'(out_we), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) apply_nl(vecs[i], i);

        // Response arrives on the same cycle the counter hits the limit: data wins.
        do_load("lb", 3'b000, 5'd5, 3'd3, 64'h1122_3344_8566_7788, 4, 64'hFFFF_FFFF_FFFF_FF85, 1'b1, 1'b0);
        do_load("lwu", 3'b110, 5'd8, 3'd4, 64'h8000_0001_0000_0000, 1, 64'h0000_0000_8000_0001, 1'b1, 1'b0);
        do_load("lw", 3'b010, 5'd8, 3'd4, 64'h8000_0001_0000_0000, 2, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0);
        do_load("ld_x0", 3'b011, 5'd0, 3'd0, 64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        do_load("illegal", 3'b111, 5'd11, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 1'b0, 1'b1);
        do_load("lhu_mis", 3'b101, 5'd12, 3'd7, 64'hAB00_0000_0000_0000, 2, 64'h0000_0000_0000_00AB, 1'b1, 1'b0);
        do_load("lh", 3'b001, 5'd13, 3'd2, 64'h0000_0000_8001_0000, 1, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0);

        inst = mk(7'd0, 3'b011, 5'd6, 7'b0000011); addr_lo = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid) got = 1'b1;
        end
        chk("to_seen", 64'(got), 64'd1);
        chk("to_err", 64'(out_err), 64'd1);
        chk("to_we", 64'(out_we), 64'd0);
        chk("to_data", out_data, 64'd0);
        chk("to_rd", 64'(out_rd), 64'd6);
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        @(posedge clk); #1;
        chk("to_late_rvalid_a", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("to_late_rvalid_b", 64'(out_valid), 64'd0);
        mem_rvalid = 1'b0;
        chk("to_ready", 64'(in_ready), 64'd1);

        inst = mk(7'd0, 3'b000, 5'd14, 7'b0000011); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_err", 64'(out_err), 64'd0);
        chk("mid_rst_rd", 64'(out_rd), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_we", 64'(out_we), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", 64'(in_ready), 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 64'hFF;
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (out_valid) got = 1'b1;
        end
        chk("mid_no_stale", 64'(got), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
